// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types, constants and baud helper
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

    localparam int UART_DATA_BITS = 8;

    function automatic int clks_per_bit(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_rx_8n1.sv
// rtl/uart_rx_8n1.sv - 8N1 receiver: RX synchronizer and oversampled receive FSM
module uart_rx_8n1
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = 25_000_000,
    parameter int BAUDRATE = 9600
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic       rx_valid,
    output logic [7:0] rx_byte,
    output logic       ferr,
    output logic       busy
);

    localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUDRATE);
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF_BIT);
    localparam logic [CNT_W-1:0] CNT_BIT  = CNT_W'(CLKS_PER_BIT - 1);

    logic             rx_meta;
    logic             rxs;
    logic             rxs_prev;
    logic [1:0]       sync_fill;
    rx_state_t        state;
    rx_state_t        state_next;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift;
    logic             tick;
    logic             start_edge;

    // rxs_prev only turns 1 once rxs carries a real pin sample, so a line held
    // low through reset cannot look like a falling edge on release.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta   <= 1'b1;
            rxs       <= 1'b1;
            rxs_prev  <= 1'b0;
            sync_fill <= 2'b00;
        end else begin
            rx_meta   <= rx;
            rxs       <= rx_meta;
            sync_fill <= {sync_fill[0], 1'b1};
            rxs_prev  <= rxs & sync_fill[1];
        end
    end

    assign tick       = (cnt == '0);
    assign start_edge = rxs_prev & ~rxs;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            rx_byte  <= '0;
            rx_valid <= 1'b0;
            ferr     <= 1'b0;
        end else begin
            state    <= state_next;
            rx_valid <= 1'b0;
            ferr     <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_edge) cnt <= CNT_HALF;
                end
                START: begin
                    if (tick) begin
                        cnt     <= CNT_BIT;
                        bit_idx <= '0;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                DATA: begin
                    if (tick) begin
                        shift[bit_idx] <= rxs;
                        bit_idx        <= bit_idx + 3'd1;
                        cnt            <= CNT_BIT;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                STOP: begin
                    if (tick) begin
                        rx_valid <= rxs;
                        ferr     <= ~rxs;
                        if (rxs) rx_byte <= shift;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (start_edge) state_next = START;
            START: if (tick) state_next = rxs ? IDLE : DATA;
            DATA:  if (tick && bit_idx == 3'(UART_DATA_BITS - 1)) state_next = STOP;
            STOP:  if (tick) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
    end

endmodule

// File: rtl/uart_rx_loader.sv
// rtl/uart_rx_loader.sv - packs received UART bytes into little-endian words for prog_mem
module uart_rx_loader
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = 25_000_000,
    parameter int BAUDRATE = 9600,
    parameter int ADDR_W   = 13
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              RX,
    output logic              WE,
    output logic [ADDR_W-1:0] A,
    output logic [31:0]       WD,
    output logic              rx_valid,
    output logic [7:0]        rx_byte,
    output logic              ferr,
    output logic              busy
);

    logic [1:0] byte_cnt;

    uart_rx_8n1 #(
        .CLK_FREQ(CLK_FREQ),
        .BAUDRATE(BAUDRATE)
    ) u_rx (
        .clk     (clk),
        .rst     (rst),
        .rx      (RX),
        .rx_valid(rx_valid),
        .rx_byte (rx_byte),
        .ferr    (ferr),
        .busy    (busy)
    );

    // WD doubles as the assembly register; the next byte cannot land while WE is high.
    always_ff @(posedge clk) begin
        if (rst) begin
            WE       <= 1'b0;
            A        <= '0;
            WD       <= '0;
            byte_cnt <= '0;
        end else begin
            WE <= rx_valid && (byte_cnt == 2'd3);
            if (rx_valid) begin
                WD[{byte_cnt, 3'b000} +: 8] <= rx_byte;
                byte_cnt                    <= byte_cnt + 2'd1;
            end
            if (WE) A <= A + ADDR_W'(1);
        end
    end

endmodule
